// File: rtl/vote_collect.sv
// vote_collect
//   Front end of the five-voter majority circuit. A start pulse opens a
//   voting window of WINDOW cycles; during the window each rising edge on a
//   voter key updates that voter's vote bit. The vote bits are held on A1..A5
//   until the next accepted start, and the downstream majority stage reads
//   them directly. done pulses for one cycle when the votes become final.
//
// Build option:
//   VOTE_LOCK_EN  defined   : a press sets the vote; later presses have no effect.
//                 undefined : each press toggles the vote (default).
//
// Ports:
//   clk          in   single rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   opens a window (only looked at in IDLE)
//   key[4:0]     in   voter keys, synchronous and debounced; bit i = voter i+1
//   A1..A5       out  registered vote bits
//   cast[2:0]    out  number of votes set, combinational from the vote registers
//   busy         out  high while the window is open
//   done         out  one-cycle pulse when the votes become final
//   remain       out  cycles left in the window, 0 outside the window
//
// State table:
//   state  | meaning
//   S_IDLE | waiting for start, votes held from the previous window
//   S_VOTE | window open, presses update votes, remain counts down
//   S_DONE | votes final, done high for this one cycle
module vote_collect #(
  parameter int WINDOW = 100,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       key,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             A4,
  output logic             A5,
  output logic [2:0]       cast,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remain
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VOTE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WINDOW_LD = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state;
  logic [4:0] key_q;
  logic [4:0] votes;
  logic [4:0] press;
  logic [4:0] next_votes;

  // A key already held when the window opens has key_q=1, so it only
  // registers after a release and a new press.
  assign press = key & ~key_q;

  always_comb begin
    next_votes = votes;
`ifdef VOTE_LOCK_EN
    next_votes = votes | press;
`else
    next_votes = votes ^ press;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      key_q  <= 5'd0;
      votes  <= 5'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      remain <= '0;
    end else begin
      key_q <= key;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          busy   <= 1'b0;
          remain <= '0;
          if (start) begin
            state  <= S_VOTE;
            votes  <= 5'd0;
            remain <= WINDOW_LD;
            busy   <= 1'b1;
          end
        end
        S_VOTE: begin
          // Presses on the closing edge still count.
          votes <= next_votes;
          if (remain <= CNT_ONE) begin
            state  <= S_DONE;
            remain <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            remain <= remain - CNT_ONE;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          remain <= '0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          remain <= '0;
        end
      endcase
    end
  end

  assign A1 = votes[0];
  assign A2 = votes[1];
  assign A3 = votes[2];
  assign A4 = votes[3];
  assign A5 = votes[4];

  always_comb begin
    cast = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cast = cast + {2'b00, votes[i]};
    end
  end

endmodule

// File: tb/tb_vote_collect.sv
module tb_vote_collect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1, start2;
  logic [4:0] key0, key1, key2;

  wire        a1_0, a2_0, a3_0, a4_0, a5_0;
  wire        a1_1, a2_1, a3_1, a4_1, a5_1;
  wire        a1_2, a2_2, a3_2, a4_2, a5_2;
  wire [2:0]  cast0, cast1, cast2;
  wire        busy0, busy1, busy2;
  wire        done0, done1, done2;
  wire [7:0]  rem0, rem1, rem2;

  wire [4:0] v0 = {a5_0, a4_0, a3_0, a2_0, a1_0};
  wire [4:0] v1 = {a5_1, a4_1, a3_1, a2_1, a1_1};
  wire [4:0] v2 = {a5_2, a4_2, a3_2, a2_2, a1_2};

  vote_collect #(.WINDOW(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst(rst), .start(start0), .key(key0),
    .A1(a1_0), .A2(a2_0), .A3(a3_0), .A4(a4_0), .A5(a5_0),
    .cast(cast0), .busy(busy0), .done(done0), .remain(rem0)
  );

  vote_collect #(.WINDOW(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .key(key1),
    .A1(a1_1), .A2(a2_1), .A3(a3_1), .A4(a4_1), .A5(a5_1),
    .cast(cast1), .busy(busy1), .done(done1), .remain(rem1)
  );

  vote_collect #(.WINDOW(6), .CNT_W(8)) u_w6 (
    .clk(clk), .rst(rst), .start(start2), .key(key2),
    .A1(a1_2), .A2(a2_2), .A3(a3_2), .A4(a4_2), .A5(a5_2),
    .cast(cast2), .busy(busy2), .done(done2), .remain(rem2)
  );

  typedef struct {
    logic [4:0] votes;
    int         done_edge;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int popcnt(input logic [4:0] v);
    int n = 0;
    for (int i = 0; i < 5; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Expected result for the window whose start is sampled on the next edge.
  task automatic expect_win(input int i, input logic [4:0] v, input int w);
    exp_t e;
    e.votes     = v;
    e.done_edge = ecnt + 1 + w;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int i, input logic d, input logic [4:0] v,
                     input logic [2:0] c);
    exp_t e;
    int   sz;
    if (d) begin
      sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done dut%0d: got done=1 expected done=0 (edge %0d)", i, ecnt);
      end else begin
        case (i)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        cmp($sformatf("dut%0d_votes", i), int'(v), int'(e.votes));
        cmp($sformatf("dut%0d_cast", i), int'(c), popcnt(e.votes));
        cmp($sformatf("dut%0d_done_edge", i), ecnt, e.done_edge);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done0, v0, cast0);
    mon(1, done1, v1, cast1);
    mon(2, done2, v2, cast2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic s, input logic [4:0] k);
    case (i)
      0: begin start0 = s; key0 = k; end
      1: begin start1 = s; key1 = k; end
      default: begin start2 = s; key2 = k; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drv(0, 1'b0, 5'd0);
    drv(1, 1'b0, 5'd0);
    drv(2, 1'b0, 5'd0);
    step();
    step();

    // Reset state
    cmp("rst_votes", int'(v0), 0);
    cmp("rst_cast", int'(cast0), 0);
    cmp("rst_busy", int'(busy0), 0);
    cmp("rst_done", int'(done0), 0);
    cmp("rst_remain", int'(rem0), 0);
    rst = 1'b0;
    step();

    // Basic window: keys 1, 3, 5
    expect_win(0, 5'b10101, 4);
    drv(0, 1'b1, 5'b00000); step();
    cmp("basic_busy", int'(busy0), 1);
    cmp("basic_remain_load", int'(rem0), 4);
    drv(0, 1'b0, 5'b00001); step();
    cmp("basic_latency_votes", int'(v0), 5'b00001);
    cmp("basic_latency_cast", int'(cast0), 1);
    drv(0, 1'b0, 5'b00000); step();
    drv(0, 1'b0, 5'b00100); step();
    drv(0, 1'b0, 5'b10000); step();
    cmp("basic_remain_end", int'(rem0), 0);
    drv(0, 1'b0, 5'b00000); step();
    cmp("basic_done_one_cycle", int'(done0), 0);
    cmp("basic_idle_busy", int'(busy0), 0);
    step(); step();
    cmp("basic_hold", int'(v0), 5'b10101);

    // Boundaries: key 4 held across start, key 2 at k+4, key 1 at k+5
    drv(0, 1'b0, 5'b01000); step();
    expect_win(0, 5'b00010, 4);
    drv(0, 1'b1, 5'b01000); step();
    cmp("bound_clear_on_start", int'(v0), 0);
    drv(0, 1'b0, 5'b01000); step();
    step();
    step();
    drv(0, 1'b0, 5'b01010); step();
    drv(0, 1'b0, 5'b01001); step();
    drv(0, 1'b0, 5'b00000); step();
    cmp("bound_after_window", int'(v0), 5'b00010);
    step();

    // Two presses of key 4: lock keeps 1, toggle returns to 0
`ifdef VOTE_LOCK_EN
    expect_win(0, 5'b01000, 4);
`else
    expect_win(0, 5'b00000, 4);
`endif
    drv(0, 1'b1, 5'b00000); step();
    drv(0, 1'b0, 5'b01000); step();
    drv(0, 1'b0, 5'b00000); step();
    drv(0, 1'b0, 5'b01000); step();
    drv(0, 1'b0, 5'b00000); step();
    step();

    // Three presses of key 4 in a 6-cycle window
    expect_win(2, 5'b01000, 6);
    drv(2, 1'b1, 5'b00000); step();
    for (int j = 1; j <= 6; j++) begin
      drv(2, 1'b0, (j % 2 == 1) ? 5'b01000 : 5'b00000);
      step();
    end
    step();

    // Start held through VOTE and DONE
    expect_win(0, 5'b00000, 4);
    drv(0, 1'b1, 5'b00000); step();
    cmp("ign_remain_0", int'(rem0), 4);
    for (int j = 1; j <= 4; j++) begin
      drv(0, 1'b1, 5'b00000); step();
      cmp($sformatf("ign_remain_%0d", j), int'(rem0), 4 - j);
    end
    drv(0, 1'b1, 5'b00000); step();
    cmp("ign_done_state_busy", int'(busy0), 0);
    drv(0, 1'b0, 5'b00000); step();
    cmp("ign_idle_busy", int'(busy0), 0);
    cmp("ign_idle_remain", int'(rem0), 0);
    step(); step();

    // Reset mid-window with start high (reset wins)
    drv(0, 1'b1, 5'b00000); step();
    drv(0, 1'b0, 5'b00001); step();
    drv(0, 1'b0, 5'b00011); step();
    cmp("midrst_remain_pre", int'(rem0), 2);
    cmp("midrst_votes_pre", int'(v0), 5'b00011);
    rst = 1'b1;
    drv(0, 1'b1, 5'b00000); step();
    cmp("midrst_votes", int'(v0), 0);
    cmp("midrst_cast", int'(cast0), 0);
    cmp("midrst_busy", int'(busy0), 0);
    cmp("midrst_remain", int'(rem0), 0);
    cmp("midrst_done", int'(done0), 0);
    rst = 1'b0;
    drv(0, 1'b0, 5'b00000);
    for (int j = 0; j < 6; j++) step();
    cmp("midrst_stay_idle", int'(busy0), 0);

    // All five keys in a 1-cycle window
    expect_win(1, 5'b11111, 1);
    drv(1, 1'b1, 5'b00000); step();
    cmp("w1_remain_load", int'(rem1), 1);
    drv(1, 1'b0, 5'b11111); step();
    cmp("w1_cast", int'(cast1), 5);
    drv(1, 1'b0, 5'b00000); step();
    step(); step();

    cmp("pending_dut0", q0.size(), 0);
    cmp("pending_dut1", q1.size(), 0);
    cmp("pending_dut2", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
